// File: rtl/nd_2to1.sv
// Two-input merge node: per-input FIFOs drained round-robin onto a single
// 4-phase req/ack output channel, with debounced req/ack inputs.

module nd_debounce #(
  parameter int CKS = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic filt_o,
  output logic ready_o
);
  localparam int CW = $clog2(CKS + 1);
  localparam logic [CW-1:0] TC = CW'(CKS - 1);

  logic [CW-1:0] cnt_q, cnt_d, settle_q, settle_d;
  logic          filt_q, filt_d, ready_q, ready_d;

  // Counter reloads whenever raw agrees with the filtered level, so only an
  // unbroken run of CKS differing samples flips the output.
  always_comb begin
    filt_d   = filt_q;
    cnt_d    = TC;
    settle_d = settle_q;
    ready_d  = ready_q;
    if (raw_i != filt_q) begin
      if (cnt_q == '0) filt_d = raw_i;
      else             cnt_d  = cnt_q - 1'b1;
    end
    if (settle_q == '0) ready_d  = 1'b1;
    else                settle_d = settle_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q   <= 1'b0;
      cnt_q    <= TC;
      settle_q <= TC;
      ready_q  <= 1'b0;
    end else begin
      filt_q   <= filt_d;
      cnt_q    <= cnt_d;
      settle_q <= settle_d;
      ready_q  <= ready_d;
    end
  end

  assign filt_o  = filt_q;
  assign ready_o = ready_q;
endmodule

module nd_fifo #(
  parameter int FSZ = 4,
  parameter int W   = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(FSZ);
  localparam int CW = $clog2(FSZ + 1);

  logic [W-1:0]  mem_q [FSZ];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(FSZ));
  assign empty_o = (count_q == '0);
  // A pop in the same cycle does not open a slot for a push into a full FIFO.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[head_q];

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (do_push) tail_d = tail_q + 1'b1;
    if (do_pop)  head_d = head_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (!do_push && do_pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[tail_q] <= din_i;
  end
endmodule

// state  | meaning
// IDLE   | no message outstanding; loads a FIFO head when one is available
// REQ    | snd0 fields valid, req_out high, waiting for filtered ack=1
// REL    | req_out low, waiting for filtered ack=0
module nd_2to1 #(
  parameter int FSZ         = 4,
  parameter int ASZ         = 4,
  parameter int DSZ         = 8,
  parameter int RSZ         = 2,
  parameter int RCV_REQ_CKS = 1,
  parameter int SND_ACK_CKS = 1
) (
  input  logic           gch_clk,
  input  logic           gch_reset,
  output logic           gch_ready,
  input  logic           rcv0_req_in,
  output logic           rcv0_ack_out,
  input  logic [ASZ-1:0] rcv0_src,
  input  logic [ASZ-1:0] rcv0_dst,
  input  logic [DSZ-1:0] rcv0_dat,
  input  logic [RSZ-1:0] rcv0_red,
  input  logic           rcv1_req_in,
  output logic           rcv1_ack_out,
  input  logic [ASZ-1:0] rcv1_src,
  input  logic [ASZ-1:0] rcv1_dst,
  input  logic [DSZ-1:0] rcv1_dat,
  input  logic [RSZ-1:0] rcv1_red,
  output logic           snd0_req_out,
  input  logic           snd0_ack_in,
  output logic [ASZ-1:0] snd0_src,
  output logic [ASZ-1:0] snd0_dst,
  output logic [DSZ-1:0] snd0_dat,
  output logic [RSZ-1:0] snd0_red
);
  localparam int MW = 2 * ASZ + DSZ + RSZ;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_REL  = 2'd2;

  logic          rdy_q;
  logic [1:0]    req_raw, req_f, req_rdy;
  logic          ack_f, ack_rdy;
  logic [1:0]    ack_q, ack_d, push, pop, full, empty;
  logic [MW-1:0] din [2];
  logic [MW-1:0] dout [2];
  logic [1:0]    state_q, state_d;
  logic          sreq_q, sreq_d, ptr_q, ptr_d, sel;
  logic [MW-1:0] msg_q, msg_d;

  assign req_raw = {rcv1_req_in, rcv0_req_in};
  assign din[0]  = {rcv0_src, rcv0_dst, rcv0_dat, rcv0_red};
  assign din[1]  = {rcv1_src, rcv1_dst, rcv1_dat, rcv1_red};

  for (genvar n = 0; n < 2; n++) begin : g_in
    nd_debounce #(.CKS(RCV_REQ_CKS)) u_req_db (
      .clk(gch_clk), .rst_n(gch_reset), .raw_i(req_raw[n]),
      .filt_o(req_f[n]), .ready_o(req_rdy[n])
    );
    nd_fifo #(.FSZ(FSZ), .W(MW)) u_fifo (
      .clk(gch_clk), .rst_n(gch_reset), .push_i(push[n]), .din_i(din[n]),
      .pop_i(pop[n]), .dout_o(dout[n]), .full_o(full[n]), .empty_o(empty[n])
    );
  end

  nd_debounce #(.CKS(SND_ACK_CKS)) u_ack_db (
    .clk(gch_clk), .rst_n(gch_reset), .raw_i(snd0_ack_in),
    .filt_o(ack_f), .ready_o(ack_rdy)
  );

  assign gch_ready = rdy_q & req_rdy[0] & req_rdy[1] & ack_rdy;

  // Ack stays high until the sender drops req, so one transaction pushes once.
  always_comb begin
    ack_d = ack_q;
    push  = '0;
    if (gch_ready) begin
      for (int n = 0; n < 2; n++) begin
        if (req_f[n] && !ack_q[n] && !full[n]) begin
          push[n]  = 1'b1;
          ack_d[n] = 1'b1;
        end else if (!req_f[n] && ack_q[n]) begin
          ack_d[n] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sreq_d  = sreq_q;
    msg_d   = msg_q;
    ptr_d   = ptr_q;
    pop     = '0;
    if (empty[0])      sel = 1'b1;
    else if (empty[1]) sel = 1'b0;
    else               sel = ptr_q;
    case (state_q)
      S_IDLE: begin
        if (gch_ready && !(empty[0] && empty[1])) begin
          pop[sel] = 1'b1;
          msg_d    = dout[sel];
          sreq_d   = 1'b1;
          ptr_d    = ~sel;
          state_d  = S_REQ;
        end
      end
      S_REQ: begin
        if (ack_f) begin
          sreq_d  = 1'b0;
          state_d = S_REL;
        end
      end
      S_REL: begin
        if (!ack_f) state_d = S_IDLE;
      end
      default: begin
        sreq_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge gch_clk or negedge gch_reset) begin
    if (!gch_reset) begin
      rdy_q   <= 1'b0;
      ack_q   <= '0;
      state_q <= S_IDLE;
      sreq_q  <= 1'b0;
      msg_q   <= '0;
      ptr_q   <= 1'b0;
    end else begin
      rdy_q   <= 1'b1;
      ack_q   <= ack_d;
      state_q <= state_d;
      sreq_q  <= sreq_d;
      msg_q   <= msg_d;
      ptr_q   <= ptr_d;
    end
  end

  assign rcv0_ack_out = ack_q[0];
  assign rcv1_ack_out = ack_q[1];
  assign snd0_req_out = sreq_q;
  assign {snd0_src, snd0_dst, snd0_dat, snd0_red} = msg_q;
endmodule

// File: tb/tb_nd_2to1.sv
// Directed bench for nd_2to1: scripted senders and a downstream receiver,
// with expected messages queued in output order and checked on delivery.

module tb_nd_2to1;
  localparam int FSZ  = 4;
  localparam int ASZ  = 4;
  localparam int DSZ  = 8;
  localparam int RSZ  = 2;
  localparam int RCKS = 3;
  localparam int ACKS = 2;
  localparam int W    = 2 * ASZ + DSZ + RSZ;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [1:0]     rcv_req;
  logic [W-1:0]   rcv_m [2];
  logic           snd_ack;
  logic           ready, ack0, ack1, snd_req;
  logic [ASZ-1:0] s_src, s_dst;
  logic [DSZ-1:0] s_dat;
  logic [RSZ-1:0] s_red;
  logic [W-1:0]   snd_msg;
  logic [W-1:0]   exp_q [$];
  int             vectors = 0;
  int             errs = 0;

  assign snd_msg = {s_src, s_dst, s_dat, s_red};

  always #5 clk = ~clk;

  nd_2to1 #(
    .FSZ(FSZ), .ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ),
    .RCV_REQ_CKS(RCKS), .SND_ACK_CKS(ACKS)
  ) dut (
    .gch_clk(clk), .gch_reset(rst_n), .gch_ready(ready),
    .rcv0_req_in(rcv_req[0]), .rcv0_ack_out(ack0),
    .rcv0_src(rcv_m[0][W-1 -: ASZ]), .rcv0_dst(rcv_m[0][W-ASZ-1 -: ASZ]),
    .rcv0_dat(rcv_m[0][RSZ+DSZ-1 -: DSZ]), .rcv0_red(rcv_m[0][RSZ-1:0]),
    .rcv1_req_in(rcv_req[1]), .rcv1_ack_out(ack1),
    .rcv1_src(rcv_m[1][W-1 -: ASZ]), .rcv1_dst(rcv_m[1][W-ASZ-1 -: ASZ]),
    .rcv1_dat(rcv_m[1][RSZ+DSZ-1 -: DSZ]), .rcv1_red(rcv_m[1][RSZ-1:0]),
    .snd0_req_out(snd_req), .snd0_ack_in(snd_ack),
    .snd0_src(s_src), .snd0_dst(s_dst), .snd0_dat(s_dat), .snd0_red(s_red)
  );

  function automatic logic [W-1:0] mk(input int src, input int dst, input int dat, input int red);
    return {ASZ'(src), ASZ'(dst), DSZ'(dat), RSZ'(red)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    bit got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      got = ready;
    end
    chk({tag, " ready"}, 32'(got), 1);
  endtask

  task automatic wait_ack_low(input int n, input string tag);
    bit low = 1'b0;
    for (int i = 0; i < 30 && !low; i++) begin
      tick();
      low = (n == 0) ? !ack0 : !ack1;
    end
    chk({tag, " ack release"}, 32'(low), 1);
  endtask

  task automatic send(input int n, input logic [W-1:0] m, input string tag);
    bit got = 1'b0;
    rcv_m[n]   = m;
    rcv_req[n] = 1'b1;
    for (int i = 0; i < 30 && !got; i++) begin
      tick();
      got = (n == 0) ? ack0 : ack1;
    end
    chk({tag, " ack"}, 32'(got), 1);
    if (got) exp_q.push_back(m);
    rcv_req[n] = 1'b0;
    wait_ack_low(n, tag);
  endtask

  task automatic recv(input string tag);
    bit           got = 1'b0;
    bit           low = 1'b0;
    logic [W-1:0] e;
    for (int i = 0; i < 60 && !got; i++) begin
      if (snd_req) got = 1'b1;
      else tick();
    end
    chk({tag, " snd req"}, 32'(got), 1);
    if (got) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
      chk({tag, " snd msg"}, 32'(snd_msg), 32'(e));
      snd_ack = 1'b1;
      for (int i = 0; i < 30 && !low; i++) begin
        tick();
        low = !snd_req;
      end
      chk({tag, " snd req release"}, 32'(low), 1);
      snd_ack = 1'b0;
      repeat (3) tick();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] m;
    logic [W-1:0] a;
    logic [W-1:0] b;
    bit           seen;
    bit           got;

    rst_n    = 1'b0;
    rcv_req  = 2'b00;
    rcv_m[0] = '0;
    rcv_m[1] = '0;
    snd_ack  = 1'b0;
    repeat (3) tick();

    // reset state
    chk("rst ready", 32'(ready), 0);
    chk("rst ack0", 32'(ack0), 0);
    chk("rst ack1", 32'(ack1), 0);
    chk("rst snd req", 32'(snd_req), 0);
    chk("rst snd msg", 32'(snd_msg), 0);
    rst_n = 1'b1;
    #1 chk("release ready", 32'(ready), 0);
    tick();
    chk("init ready", 32'(ready), 0);
    wait_ready("init");

    // single message, latency counted from the raw req edge
    m        = mk(2, 5, 'hA5, 1);
    rcv_m[0] = m;
    rcv_req[0] = 1'b1;
    repeat (3) tick();
    chk("t2 ack early", 32'(ack0), 0);
    tick();
    chk("t2 ack", 32'(ack0), 1);
    chk("t2 snd req early", 32'(snd_req), 0);
    tick();
    chk("t2 snd req", 32'(snd_req), 1);
    chk("t2 dst", 32'(s_dst), 5);
    chk("t2 dat", 32'(s_dat), 'hA5);
    exp_q.push_back(m);
    rcv_req[0] = 1'b0;
    wait_ack_low(0, "t2");
    recv("t2");

    // glitch on req shorter than the debounce window
    rcv_m[0]   = mk(6, 6, 'h66, 2);
    rcv_req[0] = 1'b1;
    tick();
    rcv_req[0] = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      tick();
      if (ack0 || snd_req) seen = 1'b1;
    end
    chk("t6 glitch", 32'(seen), 0);

    // backpressure: output stage holds one, rcv1 FIFO then fills
    send(0, mk(1, 0, 'h10, 0), "t4 r0");
    for (int k = 1; k <= FSZ; k++) send(1, mk(3, k, 'h40 + k, 2), "t4 r1");
    m          = mk(3, 7, 'h4F, 3);
    rcv_m[1]   = m;
    rcv_req[1] = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      tick();
      if (ack1) seen = 1'b1;
    end
    chk("t4 backpressure", 32'(seen), 0);
    recv("t4 drain0");
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      tick();
      got = ack1;
    end
    chk("t4 late ack", 32'(got), 1);
    if (got) exp_q.push_back(m);
    rcv_req[1] = 1'b0;
    wait_ack_low(1, "t4");
    for (int k = 0; k <= FSZ; k++) recv("t4 drain");

    // reset mid-transaction
    send(0, mk(4, 4, 'h33, 1), "t1b r0");
    rcv_m[1]   = mk(5, 5, 'h55, 2);
    rcv_req[1] = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      tick();
      got = ack1;
    end
    chk("t1b ack1 before reset", 32'(got), 1);
    chk("t1b snd req before reset", 32'(snd_req), 1);
    #3 rst_n = 1'b0;
    #1;
    chk("t1b ack1", 32'(ack1), 0);
    chk("t1b snd req", 32'(snd_req), 0);
    chk("t1b snd msg", 32'(snd_msg), 0);
    chk("t1b ready", 32'(ready), 0);
    rcv_req = 2'b00;
    exp_q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    wait_ready("t1b");
    seen = 1'b0;
    repeat (10) begin
      tick();
      if (snd_req) seen = 1'b1;
    end
    chk("t1b flushed", 32'(seen), 0);

    // concurrent pushes, then round-robin drain 0,1,0,1,0,1
    for (int k = 0; k < 3; k++) begin
      a        = mk(0, k, 'h80 + k, 0);
      b        = mk(1, k, 'hC0 + k, 1);
      rcv_m[0] = a;
      rcv_m[1] = b;
      rcv_req  = 2'b11;
      got = 1'b0;
      for (int i = 0; i < 30 && !got; i++) begin
        tick();
        got = ack0;
      end
      chk("t5 ack0", 32'(got), 1);
      chk("t5 ack1 same cycle", 32'(ack1), 1);
      if (got) begin
        exp_q.push_back(a);
        exp_q.push_back(b);
      end
      rcv_req = 2'b00;
      wait_ack_low(0, "t5 r0");
      wait_ack_low(1, "t5 r1");
    end
    for (int k = 0; k < 6; k++) recv("t3 rr");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
